// File: rtl/quickdev_bus_pkg.sv
// Shared QuickDev bus constants: arbiter FSM state encodings, requester ids
// and default widths used by the SRAM arbiter and its round-robin helper.
package quickdev_bus_pkg;

    localparam int DEF_DWIDTH      = 8;
    localparam int DEF_AWIDTH      = 19;
    localparam int DEF_WAIT_CYCLES = 2;

    // Wait counter is sized for the largest legal WAIT_CYCLES (15).
    localparam int CNT_W = 4;

    localparam logic [3:0] ST_IDLE   = 4'b0001;
    localparam logic [3:0] ST_SETUP  = 4'b0010;
    localparam logic [3:0] ST_STROBE = 4'b0100;
    localparam logic [3:0] ST_DONE   = 4'b1000;

    localparam logic PORT_AVR  = 1'b0;
    localparam logic PORT_SNES = 1'b1;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-requester round-robin decision: a lone request always wins, a tie goes
// to the port that was not granted last.
module sram_arb_rr
    import quickdev_bus_pkg::*;
(
    input  logic i_a_req,
    input  logic i_s_req,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_port
);

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        o_grant = i_a_req | i_s_req;
        o_port  = PORT_AVR;
        if (i_a_req && i_s_req) begin
            o_port = (i_last_grant == PORT_AVR) ? PORT_SNES : PORT_AVR;
        end else if (i_s_req) begin
            o_port = PORT_SNES;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the AVR and SNES requesters using a
// four-phase req/ack handshake and a fixed-length strobe per access.
module sram_arbiter
    import quickdev_bus_pkg::*;
#(
    parameter int DWIDTH      = DEF_DWIDTH,
    parameter int AWIDTH      = DEF_AWIDTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic              a_ack,
    output logic [DWIDTH-1:0] a_rdata,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [AWIDTH-1:0] s_addr,
    input  logic [DWIDTH-1:0] s_wdata,
    output logic              s_ack,
    output logic [DWIDTH-1:0] s_rdata,
    output logic [AWIDTH-1:0] sram_addr,
    output logic [DWIDTH-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DWIDTH-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    logic [3:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_port;
    logic              r_last;
    logic              r_we;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_a_rdata;
    logic [DWIDTH-1:0] r_s_rdata;
    logic              r_a_ack;
    logic              r_s_ack;

    logic w_req_valid;
    logic w_req_port;
    logic w_granted_req;
    logic w_in_setup;
    logic w_in_strobe;

    sram_arb_rr u_rr (
        .i_a_req      (a_req),
        .i_s_req      (s_req),
        .i_last_grant (r_last),
        .o_grant      (w_req_valid),
        .o_port       (w_req_port)
    );

    assign w_granted_req = (r_port == PORT_SNES) ? s_req : a_req;
    assign w_in_setup    = (r_state == ST_SETUP);
    assign w_in_strobe   = (r_state == ST_STROBE);

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_port    <= PORT_AVR;
            r_last    <= PORT_AVR;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_s_rdata <= '0;
            r_a_ack   <= 1'b0;
            r_s_ack   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        r_state <= ST_SETUP;
                        r_port  <= w_req_port;
                        r_last  <= w_req_port;
                        if (w_req_port == PORT_SNES) begin
                            r_we    <= s_we;
                            r_addr  <= s_addr;
                            r_wdata <= s_wdata;
                        end else begin
                            r_we    <= a_we;
                            r_addr  <= a_addr;
                            r_wdata <= a_wdata;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_cnt   <= CNT_LOAD;
                end
                ST_STROBE: begin
                    if (r_cnt == '0) begin
                        // Last strobe cycle: read data is valid on the bus now.
                        r_state <= ST_DONE;
                        r_a_ack <= (r_port == PORT_AVR);
                        r_s_ack <= (r_port == PORT_SNES);
                        if (!r_we) begin
                            if (r_port == PORT_SNES) r_s_rdata <= sram_dq_i;
                            else                     r_a_rdata <= sram_dq_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!w_granted_req) begin
                        r_state <= ST_IDLE;
                        r_a_ack <= 1'b0;
                        r_s_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_a_ack <= 1'b0;
                    r_s_ack <= 1'b0;
                end
            endcase
        end
    end

    assign sram_addr  = r_addr;
    assign sram_dq_o  = r_wdata;
    assign sram_dq_oe = (w_in_setup | w_in_strobe) & r_we;
    assign sram_ce_n  = ~(w_in_setup | w_in_strobe);
    assign sram_we_n  = ~(w_in_strobe & r_we);
    assign sram_oe_n  = ~(w_in_strobe & ~r_we);

    assign a_ack   = r_a_ack;
    assign s_ack   = r_s_ack;
    assign a_rdata = r_a_rdata;
    assign s_rdata = r_s_rdata;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DWIDTH, default 8, data width of both requesters and the SRAM.
REQ-002 Parameter AWIDTH, default 19, SRAM address width.
REQ-003 Parameter WAIT_CYCLES, default 2, strobe length in clk cycles; legal range 1..15.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 a_req, a_we, a_addr[AWIDTH], a_wdata[DWIDTH]  in; AVR request, write-enable (1=write), address, write data.
REQ-007 a_ack  out  1, a_rdata  out  DWIDTH; AVR acknowledge and read data.
REQ-008 s_req, s_we, s_addr, s_wdata  in; s_ack, s_rdata  out; SNES port, same widths and meaning as AVR.
REQ-009 sram_addr  out  AWIDTH; sram_dq_o  out  DWIDTH; sram_dq_oe  out  1; sram_dq_i  in  DWIDTH; the tristate buffer is instantiated at top level.
REQ-010 sram_ce_n, sram_we_n, sram_oe_n  out  1 each; active-low SRAM strobes.

Function
REQ-011 Each port SHALL use a four-phase handshake: req rises -> ack rises when the access is done -> req falls -> ack falls.
REQ-012 The requester SHALL hold we, addr and wdata stable while req is high.
REQ-013 The FSM SHALL have the states IDLE, SETUP, STROBE and DONE, one-hot encoded.
REQ-014 IDLE -> SETUP when any req is high, latching the winner's port id, we, addr and wdata.
REQ-015 SETUP -> STROBE after 1 cycle, loading the wait counter with WAIT_CYCLES-1.
REQ-016 STROBE -> DONE when the counter reaches 0; the counter decrements once per cycle.
REQ-017 DONE -> IDLE in the first cycle in which the granted req is low.
REQ-018 Tie-break: when both reqs are high in IDLE, the port not granted last SHALL win (round-robin).
REQ-019 After reset, the SNES port SHALL win the first tie.
REQ-020 A single pending req SHALL be granted regardless of the round-robin pointer.
REQ-021 sram_ce_n SHALL be low during SETUP and STROBE, and high otherwise.
REQ-022 sram_we_n SHALL be low only during STROBE of a write.
REQ-023 sram_oe_n SHALL be low only during STROBE of a read.
REQ-024 sram_dq_oe SHALL be high during SETUP and STROBE of a write only.
REQ-025 sram_addr and sram_dq_o SHALL hold the latched values from SETUP through DONE.
REQ-026 Reads: sram_dq_i SHALL be captured on the last STROBE cycle into the granted port's rdata only; the other port's rdata is unchanged.
REQ-027 Latency: ack SHALL be registered and rise exactly WAIT_CYCLES+2 cycles after the IDLE cycle that sampled req.
REQ-028 Ack SHALL stay high for the whole DONE state and only for the granted port.
REQ-029 A req arriving on the other port during an access SHALL wait and be granted on the next IDLE.
REQ-030 Back-to-back accesses SHALL have a minimum of one IDLE cycle between DONE and the next SETUP.
REQ-031 If the granted req falls before ack (protocol violation), the access SHALL still complete and DONE SHALL exit after one cycle.

Reset
REQ-032 While reset is high at a clock edge: state IDLE; a_ack=s_ack=0; sram_ce_n=sram_we_n=sram_oe_n=1; sram_dq_oe=0.
REQ-033 On the same reset edge: sram_addr=0, sram_dq_o=0, a_rdata=s_rdata=0, round-robin pointer=AVR (so SNES wins the first tie).
REQ-034 Reset asserted mid-access (any state) SHALL abort the access at the next edge with no further strobe activity and no ack.

Structure
REQ-035 Package quickdev_bus_pkg SHALL hold the state encodings, the port-id constants (PORT_AVR, PORT_SNES) and the default width parameters.
REQ-036 The round-robin decision (two reqs, last-grant pointer -> grant, port id) SHALL be the sub-module sram_arb_rr; the FSM, counter and datapath stay in sram_arbiter.

Verification
REQ-037 AVR write addr 0x12345 data 0xA5, WAIT_CYCLES=2 -> sram_we_n low for exactly 2 cycles with dq_o=0xA5 and dq_oe=1; a_ack rises 4 cycles after req is sampled.
REQ-038 SNES read addr 0x00010, sram_dq_i=0x3C -> s_rdata=0x3C with s_ack high; a_rdata unchanged; sram_oe_n low 2 cycles; dq_oe stays 0.
REQ-039 Both reqs high in the same cycle after reset, held for 3 rounds -> grant order SNES, AVR, SNES, with each ack low before the next SETUP.
REQ-040 AVR req rises while SNES is in STROBE -> AVR SETUP starts one cycle after the DONE->IDLE transition; no strobe overlap.
REQ-041 Reset pulsed during STROBE of a write -> next cycle all strobes high, dq_oe=0, acks 0, rdata 0; a fresh req then completes normally.
REQ-042 WAIT_CYCLES=1 and WAIT_CYCLES=15 builds -> strobe length 1 and 15 cycles respectively; ack latency 3 and 17 cycles.
